riscv_mc_controller: RTL

Multi-cycle control unit for the RV32I core. It sequences the shared ALU, register file, instruction/data memory port and PC through a Moore FSM, one instruction at a time. It generates the 4-bit ALUControl consumed by the existing ALU and uses the ALU Zero flag to resolve branches. It sits between the instruction register (op/funct fields) and the multi-cycle datapath muxes and enables.

---
 rtl/riscv_pkg.sv | 93 +++++++++
 rtl/riscv_mc_controller_if.sv | 36 +++
 rtl/alu_decoder.sv | 37 +++
 rtl/riscv_mc_controller.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: FSM states,
// ALUControl codes, opcodes, ALUOp codes and datapath mux selects.
package riscv_pkg;

  // Controller states, one instruction at a time.
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL
  } state_t;

  // ALUOp selects the broad class of ALU work; ALUOP_FUNCT defers to funct3/funct7.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  // ALUControl codes understood by the existing ALU.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Supported major opcodes (instr[6:0]).
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ResultSrc selects.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA selects.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  // ALUSrcB selects.
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ImmSrc selects.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Per-state Moore control word; PCWrite is derived from pc_update/branch.
  typedef struct packed {
    logic    pc_update;
    logic    branch;
    logic    adr_src;
    logic    mem_write;
    logic    ir_write;
    logic    reg_write;
    logic    illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t alu_op;
  } ctrl_t;

  // Immediate format implied by the opcode; anything else is treated as I-type.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mc_controller_if.sv
// Control bundle between the multi-cycle controller and its datapath:
// instruction fields and ALU flag in, enables and mux selects out.
interface riscv_mc_controller_if;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       Illegal;

  // Controller side.
  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal
  );

  // Datapath side.
  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal
  );

endinterface

// File: rtl/alu_decoder.sv
// ALU decoder: maps ALUOp plus funct3/funct7b5/op[5] to the 4-bit ALUControl.
// Purely combinational so a later pipelined core can reuse it unchanged.
module alu_decoder
  import riscv_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alu_control
);

  // Select the ALU operation from the op class and function fields.
  always_comb begin
    // NOTE: every output gets a value before the case so no path can infer a latch.
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) uses funct7b5 for sub; addi must stay an add.
          3'b000: alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b011: alu_control = ALU_SLTU;
          3'b100: alu_control = ALU_XOR;
          3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV32I control unit: Moore FSM sequencing the shared ALU,
// register file, memory port and PC; PCWrite is the one Mealy output.
module riscv_mc_controller
  import riscv_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  riscv_mc_controller_if.master   bus
);

  state_t     state;
  state_t     state_next;
  state_t     state_eff;
  ctrl_t      ctrl;
  logic [3:0] alu_control;

  // While reset is held the outputs look like FETCH regardless of the
  // register contents, so an aborted instruction cannot leak a write.
  assign state_eff = reset ? S_FETCH : state;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state and per-state control word.
  always_comb begin
    ctrl       = '0;
    state_next = state_eff;
    case (state_eff)
      S_FETCH: begin
        ctrl.adr_src    = 1'b0;
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.pc_update  = 1'b1;
        state_next      = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALUOut while decoding.
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        case (bus.op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          default: begin
            ctrl.illegal = 1'b1;
            state_next   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        // op[5] separates stores (0100011) from loads (0000011).
        state_next     = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.adr_src    = 1'b1;
        state_next      = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
        state_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.adr_src    = 1'b1;
        ctrl.mem_write  = 1'b1;
        state_next      = S_FETCH;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_next     = S_ALUWB;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_next     = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        state_next      = S_FETCH;
      end
      S_BRANCH: begin
        // Compare rs1-rs2 in the ALU; the target already sits in ALUOut.
        ctrl.alu_src_a  = SRCA_REG;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
        state_next      = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
        state_next      = S_ALUWB;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl.alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (alu_control)
  );

  // funct3[0] distinguishes beq (take on Zero) from bne (take on !Zero).
  assign bus.PCWrite    = !reset && (ctrl.pc_update ||
                                     (ctrl.branch && (bus.Zero ^ bus.funct3[0])));
  assign bus.IRWrite    = !reset && ctrl.ir_write;
  assign bus.MemWrite   = !reset && ctrl.mem_write;
  assign bus.RegWrite   = !reset && ctrl.reg_write;
  assign bus.Illegal    = !reset && ctrl.illegal;
  assign bus.AdrSrc     = ctrl.adr_src;
  assign bus.ResultSrc  = ctrl.result_src;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = imm_src_of(bus.op);

endmodule
